// File: rtl/slot_allocator_pkg.sv
// Shared definitions for the slot allocator: index width helper, status bit map, mode encoding.
package slot_allocator_pkg;

  // Ceiling log2, used to size slot indices from the slot count.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Bit positions of the sticky error flags in the status register.
  localparam int ERR_DOUBLE_FREE_BIT = 0;
  localparam int ERR_OVERFLOW_BIT    = 1;
  localparam int ERR_W               = 2;

  // FLUSH only ever lasts the cycle the flush input is high.
  typedef enum logic {
    MODE_NORMAL = 1'b0,
    MODE_FLUSH  = 1'b1
  } mode_t;

endpackage

// File: rtl/slot_allocator_zc.sv
// zc: first-zero finder. Reports the lowest index holding a 0 and whether any zero exists.
module zc #(
  parameter int N      = 8,
  parameter int ADDR_W = 3
)(
  input  logic [N-1:0]      seq,
  output logic [ADDR_W-1:0] addr,
  output logic              has_zero
);

  // Scan from the top down so the lowest zero wins; addr stays 0 when seq is all ones.
  always_comb begin
    addr     = '0;
    has_zero = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!seq[i]) begin
        addr     = ADDR_W'(i);
        has_zero = 1'b1;
      end
    end
  end

endmodule

// File: rtl/slot_allocator.sv
// slot_allocator: occupancy bitmap with lowest-free-slot offer, free port, flush, counters, sticky errors.
module slot_allocator
  import slot_allocator_pkg::*;
#(
  parameter int N      = 8,
  parameter int ADDR_W = clog2(N)
)(
  input  logic              clk,
  input  logic              rst,
  output logic              alloc_valid,
  input  logic              alloc_ready,
  output logic [ADDR_W-1:0] alloc_addr,
  input  logic              free_valid,
  input  logic [ADDR_W-1:0] free_addr,
  input  logic              flush,
  output logic [N-1:0]      occ,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              err_double_free,
  output logic              err_overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(N);

  logic [N-1:0]     occ_q, occ_nxt;
  logic [ADDR_W:0]  cnt_q, cnt_nxt;
  logic             full_q, empty_q;
  logic [ERR_W-1:0] err_q, err_nxt;
  mode_t            mode;
  logic             alloc_fire, free_hit, double_free, overflow;

  // Offer comes straight from the registered bitmap: a freed slot is never bypassed into the same cycle.
  zc #(.N(N), .ADDR_W(ADDR_W)) u_zc (
    .seq      (occ_q),
    .addr     (alloc_addr),
    .has_zero (alloc_valid)
  );

  // Decode request qualifiers against the current bitmap; a free of an occupied slot can never
  // collide with the offered slot, which is by construction unoccupied.
  always_comb begin
    mode        = flush ? MODE_FLUSH : MODE_NORMAL;
    alloc_fire  = alloc_valid & alloc_ready;
    free_hit    = free_valid & occ_q[free_addr];
    double_free = free_valid & ~occ_q[free_addr];
    overflow    = alloc_ready & ~alloc_valid;
  end

  // Next bitmap, count and error state; flush drops all requests and raises no errors.
  always_comb begin
    occ_nxt = occ_q;
    cnt_nxt = cnt_q;
    err_nxt = err_q;
    case (mode)
      MODE_FLUSH: begin
        occ_nxt = '0;
        cnt_nxt = '0;
      end
      default: begin
        if (alloc_fire) occ_nxt[alloc_addr] = 1'b1;
        if (free_hit)   occ_nxt[free_addr]  = 1'b0;
        if (alloc_fire && !free_hit)      cnt_nxt = cnt_q + 1'b1;
        else if (free_hit && !alloc_fire) cnt_nxt = cnt_q - 1'b1;
        if (double_free) err_nxt[ERR_DOUBLE_FREE_BIT] = 1'b1;
        if (overflow)    err_nxt[ERR_OVERFLOW_BIT]    = 1'b1;
      end
    endcase
  end

  // State register; full/empty are registered from the next count so they track count exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= '0;
    end else begin
      occ_q   <= occ_nxt;
      cnt_q   <= cnt_nxt;
      full_q  <= (cnt_nxt == FULL_CNT);
      empty_q <= (cnt_nxt == '0);
      err_q   <= err_nxt;
    end
  end

  assign occ             = occ_q;
  assign count           = cnt_q;
  assign full            = full_q;
  assign empty           = empty_q;
  assign err_double_free = err_q[ERR_DOUBLE_FREE_BIT];
  assign err_overflow    = err_q[ERR_OVERFLOW_BIT];

endmodule

// File: tb/tb_slot_allocator.sv
// Randomized + directed bench for slot_allocator with a queue-based scoreboard.
module tb_slot_allocator;

  localparam int N      = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [ADDR_W-1:0] alloc_addr;
  logic              free_valid;
  logic [ADDR_W-1:0] free_addr;
  logic              flush;
  logic [N-1:0]      occ;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              err_double_free;
  logic              err_overflow;

  slot_allocator #(.N(N), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_valid     (alloc_valid),
    .alloc_ready     (alloc_ready),
    .alloc_addr      (alloc_addr),
    .free_valid      (free_valid),
    .free_addr       (free_addr),
    .flush           (flush),
    .occ             (occ),
    .count           (count),
    .full            (full),
    .empty           (empty),
    .err_double_free (err_double_free),
    .err_overflow    (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int valid, addr, occ, count, full, empty, edf, eovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a set of in-use slots plus two sticky flags.
  bit in_use[N];
  bit m_edf, m_eovf;

  function automatic int lowest_free();
    for (int i = 0; i < N; i++) if (!in_use[i]) return i;
    return -1;
  endfunction

  function automatic int used_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += in_use[i];
    return c;
  endfunction

  function automatic int occ_word();
    int w = 0;
    for (int i = 0; i < N; i++) if (in_use[i]) w += (1 << i);
    return w;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int lf = lowest_free();
    int c  = used_count();
    e.valid = (lf >= 0);
    e.addr  = (lf >= 0) ? lf : 0;
    e.occ   = occ_word();
    e.count = c;
    e.full  = (c == N);
    e.empty = (c == 0);
    e.edf   = m_edf;
    e.eovf  = m_eovf;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) in_use[i] = 1'b0;
    m_edf  = 1'b0;
    m_eovf = 1'b0;
  endtask

  // Apply one cycle of stimulus: expected outputs for this cycle go to the scoreboard, model advances at the edge.
  task automatic step(input bit r, input bit fl, input bit ar, input bit fv, input int fa);
    int lf;
    rst = r; flush = fl; alloc_ready = ar; free_valid = fv; free_addr = ADDR_W'(fa);
    exp_q.push_back(predict());
    @(posedge clk);
    if (r) model_reset();
    else if (fl) for (int i = 0; i < N; i++) in_use[i] = 1'b0;
    else begin
      lf = lowest_free();
      if (fv && !in_use[fa]) m_edf = 1'b1;
      if (fv) in_use[fa] = 1'b0;
      if (ar && lf >= 0) in_use[lf] = 1'b1;
      if (ar && lf < 0) m_eovf = 1'b1;
    end
    #1;
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0); endtask
  task automatic alloc(); step(0, 0, 1, 0, 0); endtask
  task automatic free_slot(input int a); step(0, 0, 0, 1, a); endtask
  task automatic do_reset(); step(1, 0, 0, 0, 0); endtask

  task automatic cmp(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: outputs are present every cycle, so compare each one against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("alloc_valid", int'(alloc_valid), e.valid);
      if (e.valid != 0) cmp("alloc_addr", int'(alloc_addr), e.addr);
      else              cmp("alloc_addr_idle", int'(alloc_addr), 0);
      cmp("occ", int'(occ), e.occ);
      cmp("count", int'(count), e.count);
      cmp("full", int'(full), e.full);
      cmp("empty", int'(empty), e.empty);
      cmp("err_double_free", int'(err_double_free), e.edf);
      cmp("err_overflow", int'(err_overflow), e.eovf);
    end
  end

  initial begin
    // Bring the DUT out of its unknown power-up state before predictions start.
    rst = 1'b1; flush = 1'b0; alloc_ready = 1'b0; free_valid = 1'b0; free_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state and fill 0..7.
    do_reset();
    idle();
    repeat (8) alloc();
    idle();
    // Hole fill: free 2 then 5, allocate twice.
    free_slot(2); free_slot(5); alloc(); alloc(); idle();

    // Simultaneous alloc + free from occ = 8'b00001011.
    do_reset();
    repeat (4) alloc();
    free_slot(2);
    step(0, 0, 1, 1, 0);
    idle();

    // Full plus free: no same-cycle bypass.
    do_reset();
    repeat (8) alloc();
    free_slot(3);
    idle();

    // Errors: double free, overflow, persistence through flush, cleared by reset.
    do_reset();
    free_slot(6);
    repeat (8) alloc();
    alloc();
    step(0, 1, 0, 0, 0);
    idle();
    do_reset();
    idle();

    // Flush with alloc_ready from occ = 8'h3C; then reset mid-fill.
    repeat (6) alloc();
    free_slot(0); free_slot(1);
    step(0, 1, 1, 0, 0);
    idle();
    repeat (3) alloc();
    step(1, 0, 1, 0, 0);
    idle();

    // Random traffic with occasional flush/reset.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 39) == 0),
           $urandom_range(0, 1), ($urandom_range(0, 2) == 0), $urandom_range(0, N - 1));
    end
    idle();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slot_allocator.md
Name: slot_allocator

Overview:
- Allocates and frees entries of an N-slot buffer, e.g. the partial-sum or index buffers of the sparse accelerator.
- Holds an occupancy bitmap (bit i = 1 means slot i is in use).
- Uses a `zc` first-zero finder on that bitmap to offer the lowest-index free slot to one requester through a valid/ready handshake.
- Accepts frees from a second port, and tracks count, full, empty and misuse errors.

Parameters:
- N, 8, number of slots. Must be a power of two, at least 2.
- ADDR_W, 3, slot index width; equals log2(N).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  out  1  a free slot is offered this cycle.
- alloc_ready  in  1  requester takes the offered slot.
- alloc_addr  out  ADDR_W  offered slot index; meaningful only while alloc_valid = 1.
- free_valid  in  1  release the slot at free_addr.
- free_addr  in  ADDR_W  slot index to release.
- flush  in  1  release all slots.
- occ  out  N  registered occupancy bitmap.
- count  out  ADDR_W+1  number of occupied slots, 0..N.
- full  out  1  count == N.
- empty  out  1  count == 0.
- err_double_free  out  1  sticky; set by a free of a slot that is already free.
- err_overflow  out  1  sticky; set by alloc_ready asserted while alloc_valid = 0.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - occ = 0, count = 0, empty = 1, full = 0.
  - Both error flags = 0.
  - alloc_valid rises in the first cycle after reset with alloc_addr = 0.
- Offer path (combinational from registered occ):
  - alloc_valid = has_zero of `zc`(occ).
  - alloc_addr = lowest index i with occ[i] = 0.
  - Example: occ = 8'b00001011 gives alloc_addr = 2.
  - When occ is all ones: alloc_valid = 0, alloc_addr = 0.
- Allocation fires when alloc_valid && alloc_ready: occ[alloc_addr] <= 1 at the next edge.
- Free fires when free_valid:
  - occ[free_addr] <= 0 at the next edge.
  - If occ[free_addr] was already 0, occ is unchanged, count is unchanged and err_double_free is set.
- Latency:
  - An allocated slot is excluded from the offer starting the next cycle.
  - A freed slot becomes offerable starting the next cycle; there is no same-cycle bypass. While full, a same-cycle free does not raise alloc_valid that cycle.
- Simultaneous allocation and valid free in one cycle:
  - Both bitmap updates apply.
  - count is unchanged.
  - The two slots are always distinct: the allocated slot is free, the freed slot is occupied.
- count update: +1 on allocation only, -1 on valid free only, otherwise held. It never wraps.
- full and empty are registered and consistent with count in the same cycle.
- flush:
  - Highest priority below rst.
  - Next state: occ = 0, count = 0.
  - Allocations and frees in that cycle are ignored; no error flags are set.
  - Error flags are not cleared by flush.
- err_overflow: set when alloc_ready = 1 and alloc_valid = 0. No state change results.
- Error flags clear only on rst.
- Out-of-range addresses: none exist, since N is a power of two.
- Reset mid-operation:
  - Any in-flight handshake is dropped.
  - The requester must discard a slot accepted in the same cycle that rst = 1.
- FSM: two implicit modes, NORMAL and FLUSH.
  - FLUSH lasts one cycle, driven by the flush input.
  - No further states are needed.

Decomposition:
- Shared package:
  - slot index width function (clog2).
  - Error flag bit positions for the status register.
- Sub-module: the existing `zc` #(N, ADDR_W) instance.
  - seq = occ.
  - Its outputs addr and has_zero are used directly as alloc_addr and alloc_valid.
- All other logic is in slot_allocator.

Test Plan:
- Fill: reset, hold alloc_ready = 1 for 8 cycles -> alloc_addr runs 0,1,…,7; occ = 8'hFF; count = 8; full = 1; alloc_valid = 0.
- Hole fill: with occ = 8'hFF, free 2 then free 5 on consecutive cycles, then allocate twice -> occ passes 8'hFB, 8'hDB; allocations return 2 then 5; occ back to 8'hFF.
- Simultaneous: with occ = 8'b00001011, alloc_ready = 1 and free_valid = 1 with free_addr = 0 in one cycle -> occ = 8'b00001110, count stays 3; next offer is alloc_addr = 0.
- Full plus free: with occ = 8'hFF, free 3 -> alloc_valid = 0 that cycle, alloc_valid = 1 with alloc_addr = 3 the next cycle.
- Errors: free slot 6 while occ[6] = 0 -> err_double_free = 1, count unchanged. alloc_ready while full -> err_overflow = 1. Both flags persist through a flush and clear on rst.
- Flush/reset: flush with alloc_ready = 1 and occ = 8'h3C -> next cycle occ = 0, count = 0, empty = 1. Assert rst mid-fill -> all outputs return to their reset values.
